// File: rtl/imem_loader.sv
// Instruction-memory boot loader.
// Accepts a framed word stream (header N, N payload words, checksum),
// writes the payload into instruction memory starting at BASE_ADDR and
// holds the CPU in reset until a load completes with a matching checksum.
module imem_loader #(
    parameter logic [9:0] BASE_ADDR = 10'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    input  logic [9:0] in_data,
    output logic       in_ready,
    output logic       mem_we,
    output logic [9:0] mem_addr,
    output logic [9:0] mem_wdata,
    output logic       cpu_hold,
    output logic       done,
    output logic       error,
    output logic [9:0] words_loaded
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    state_t     state_r;
    state_t     state_next_s;
    logic       xfer_s;
    logic       last_word_s;

    logic [9:0] n_r;
    logic [9:0] idx_r;
    logic [9:0] sum_r;
    logic       mem_we_r;
    logic [9:0] mem_addr_r;
    logic [9:0] mem_wdata_r;
    logic       cpu_hold_r;
    logic       done_r;
    logic       error_r;
    logic [9:0] words_loaded_r;

    // Stream handshake: ready is a pure decode of the receiving states.
    always_comb begin
        in_ready    = 1'b0;
        xfer_s      = 1'b0;
        last_word_s = 1'b0;
        if ((state_r == HDR) || (state_r == DATA) || (state_r == CSUM)) begin
            in_ready = 1'b1;
        end else begin
            in_ready = 1'b0;
        end
        xfer_s      = in_ready & in_valid;
        last_word_s = (idx_r == (n_r - 10'd1));
    end

    // State register; reset forces IDLE immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; start is only honoured in IDLE, DONE and ERR.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = HDR;
                end else begin
                    state_next_s = IDLE;
                end
            end
            HDR: begin
                if (xfer_s) begin
                    if (in_data == 10'd0) begin
                        state_next_s = ERR;
                    end else begin
                        state_next_s = DATA;
                    end
                end else begin
                    state_next_s = HDR;
                end
            end
            DATA: begin
                if (xfer_s && last_word_s) begin
                    state_next_s = CSUM;
                end else begin
                    state_next_s = DATA;
                end
            end
            CSUM: begin
                if (xfer_s) begin
                    if (in_data == sum_r) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = ERR;
                    end
                end else begin
                    state_next_s = CSUM;
                end
            end
            DONE, ERR: begin
                if (start) begin
                    state_next_s = HDR;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Datapath: header latch, payload write strobe/address/data, running
    // checksum and the registered status flags (aligned with the state).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_r            <= 10'd0;
            idx_r          <= 10'd0;
            sum_r          <= 10'd0;
            mem_we_r       <= 1'b0;
            mem_addr_r     <= 10'd0;
            mem_wdata_r    <= 10'd0;
            cpu_hold_r     <= 1'b1;
            done_r         <= 1'b0;
            error_r        <= 1'b0;
            words_loaded_r <= 10'd0;
        end else begin
            mem_we_r   <= 1'b0;
            cpu_hold_r <= (state_next_s != DONE);
            done_r     <= (state_next_s == DONE);
            error_r    <= (state_next_s == ERR);
            case (state_r)
                HDR: begin
                    if (xfer_s) begin
                        // A zero header still starts a fresh (empty) load.
                        idx_r          <= 10'd0;
                        sum_r          <= 10'd0;
                        words_loaded_r <= 10'd0;
                        if (in_data != 10'd0) begin
                            n_r <= in_data;
                        end else begin
                            n_r <= n_r;
                        end
                    end else begin
                        n_r <= n_r;
                    end
                end
                DATA: begin
                    if (xfer_s) begin
                        mem_we_r       <= 1'b1;
                        mem_addr_r     <= BASE_ADDR + idx_r;
                        mem_wdata_r    <= in_data;
                        idx_r          <= idx_r + 10'd1;
                        words_loaded_r <= words_loaded_r + 10'd1;
                        sum_r          <= sum_r + in_data;
                    end else begin
                        idx_r <= idx_r;
                    end
                end
                default: begin
                    idx_r <= idx_r;
                end
            endcase
        end
    end

    assign mem_we       = mem_we_r;
    assign mem_addr     = mem_addr_r;
    assign mem_wdata    = mem_wdata_r;
    assign cpu_hold     = cpu_hold_r;
    assign done         = done_r;
    assign error        = error_r;
    assign words_loaded = words_loaded_r;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a cycle table for the basic load,
// then directed sequences for checksum error, zero header, address wrap,
// stalls with ignored start, and reset in the middle of a load.
module tb_imem_loader;

    logic       clk;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic [9:0] in_data;

    logic       in_ready, mem_we, cpu_hold, done, error;
    logic [9:0] mem_addr, mem_wdata, words_loaded;
    logic       in_ready2, mem_we2, cpu_hold2, done2, error2;
    logic [9:0] mem_addr2, mem_wdata2, words_loaded2;

    int checks = 0;
    int errors = 0;

    logic [9:0]  stim_q[$];
    logic [19:0] wr_q[$];
    logic [19:0] wr2_q[$];

    typedef struct {
        logic       start;
        logic       valid;
        logic [9:0] data;
        logic [34:0] exp;   // {rdy, we, addr, wdata, hold, done, err, wl}
    } vec_t;

    vec_t vecs[7];

    imem_loader dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error), .words_loaded(words_loaded)
    );

    imem_loader #(.BASE_ADDR(10'd1022)) dut2 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .cpu_hold(cpu_hold2), .done(done2), .error(error2), .words_loaded(words_loaded2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every memory write of both instances just after the edge.
    always @(posedge clk) begin
        #1;
        if (mem_we === 1'b1) wr_q.push_back({mem_addr, mem_wdata});
        if (mem_we2 === 1'b1) wr2_q.push_back({mem_addr2, mem_wdata2});
    end

    function automatic logic [34:0] outs();
        return {in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error, words_loaded};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 10'd0;
        @(negedge clk);
        rst = 1'b0;
        wr_q.delete();
        wr2_q.delete();
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drive stim_q one word per cycle; optional random bubbles with start
    // pulses that the loader must ignore.
    task automatic send(input bit gaps);
        for (int i = 0; i < stim_q.size(); i++) begin
            if (gaps && i == 2) begin
                @(negedge clk); start = 1'b1; in_valid = 1'b0;
            end
            if (gaps) begin
                for (int g = 0; g < 3; g++) begin
                    if ($urandom_range(0, 1) == 1) begin
                        @(negedge clk);
                        start = 1'($urandom_range(0, 1));
                        in_valid = 1'b0;
                        in_data = 10'($urandom_range(0, 1023));
                    end
                end
            end
            @(negedge clk);
            start = 1'b0; in_valid = 1'b1; in_data = stim_q[i];
        end
        @(negedge clk);
        in_valid = 1'b0; start = 1'b0;
    endtask

    // Compare captured writes with the payload placed at base+i (10-bit wrap).
    task automatic check_writes(input string nm, input bit second, input logic [9:0] base);
        int n;
        logic [9:0] a;
        n = int'(stim_q[0]);
        if (second) chk({nm, "_count"}, 64'(wr2_q.size()), 64'(n));
        else        chk({nm, "_count"}, 64'(wr_q.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            a = base + 10'(i);
            if (second && i < wr2_q.size()) chk({nm, "_wr"}, 64'(wr2_q[i]), 64'({a, stim_q[i+1]}));
            if (!second && i < wr_q.size()) chk({nm, "_wr"}, 64'(wr_q[i]), 64'({a, stim_q[i+1]}));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 10'd0;
        vecs[0] = '{1'b1, 1'b1, 10'h003, {1'b1, 1'b0, 10'h000, 10'h000, 1'b1, 1'b0, 1'b0, 10'd0}};
        vecs[1] = '{1'b0, 1'b1, 10'h003, {1'b1, 1'b0, 10'h000, 10'h000, 1'b1, 1'b0, 1'b0, 10'd0}};
        vecs[2] = '{1'b0, 1'b1, 10'h101, {1'b1, 1'b1, 10'h000, 10'h101, 1'b1, 1'b0, 1'b0, 10'd1}};
        vecs[3] = '{1'b1, 1'b1, 10'h002, {1'b1, 1'b1, 10'h001, 10'h002, 1'b1, 1'b0, 1'b0, 10'd2}};
        vecs[4] = '{1'b0, 1'b1, 10'h0FF, {1'b1, 1'b1, 10'h002, 10'h0FF, 1'b1, 1'b0, 1'b0, 10'd3}};
        vecs[5] = '{1'b0, 1'b1, 10'h202, {1'b0, 1'b0, 10'h002, 10'h0FF, 1'b0, 1'b1, 1'b0, 10'd3}};
        vecs[6] = '{1'b0, 1'b0, 10'h000, {1'b0, 1'b0, 10'h002, 10'h0FF, 1'b0, 1'b1, 1'b0, 10'd3}};

        #3;
        chk("reset_outputs", 64'(outs()), 64'({1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 10'd0}));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic load, one vector per cycle; start in DATA is ignored.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            start = vecs[i].start; in_valid = vecs[i].valid; in_data = vecs[i].data;
            @(posedge clk);
            #1;
            chk($sformatf("table_%0d", i), 64'(outs()), 64'(vecs[i].exp));
        end
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;

        // Checksum mismatch, then restart from ERR with a correct stream.
        wr_q.delete();
        do_start();
        chk("restart_from_done", 64'({done, cpu_hold, in_ready}), 64'({1'b0, 1'b1, 1'b1}));
        stim_q = '{10'd3, 10'h101, 10'h002, 10'h0FF, 10'h203};
        send(1'b0);
        chk("bad_csum_flags", 64'({error, done, cpu_hold, words_loaded}),
            64'({1'b1, 1'b0, 1'b1, 10'd3}));
        check_writes("bad_csum", 1'b0, 10'd0);
        wr_q.delete();
        do_start();
        chk("err_cleared", 64'({error, done, cpu_hold}), 64'({1'b0, 1'b0, 1'b1}));
        stim_q = '{10'd3, 10'h101, 10'h002, 10'h0FF, 10'h202};
        send(1'b0);
        chk("recover_flags", 64'({error, done, cpu_hold}), 64'({1'b0, 1'b1, 1'b0}));

        // Zero-length header.
        reset_dut();
        do_start();
        stim_q = '{10'd0};
        send(1'b0);
        chk("zero_hdr_flags", 64'({error, done, cpu_hold, words_loaded}),
            64'({1'b1, 1'b0, 1'b1, 10'd0}));
        chk("zero_hdr_no_write", 64'(wr_q.size()), 64'd0);

        // Address wrap on the BASE_ADDR=1022 instance.
        reset_dut();
        do_start();
        stim_q = '{10'd4, 10'd1, 10'd2, 10'd3, 10'd4, 10'd10};
        send(1'b0);
        chk("wrap_done", 64'({done2, error2, cpu_hold2, words_loaded2}),
            64'({1'b1, 1'b0, 1'b0, 10'd4}));
        check_writes("wrap", 1'b1, 10'd1022);

        // Random in_valid bubbles with ignored start pulses (restart from DONE).
        wr_q.delete();
        do_start();
        chk("start_from_done", 64'({done, cpu_hold}), 64'({1'b0, 1'b1}));
        stim_q = '{10'd5, 10'h011, 10'h3F0, 10'h123, 10'h200, 10'h0AB, 10'h3CF};
        send(1'b1);
        chk("gaps_done", 64'({done, error, cpu_hold, words_loaded}),
            64'({1'b1, 1'b0, 1'b0, 10'd5}));
        check_writes("gaps", 1'b0, 10'd0);

        // Stall then reset mid-DATA, pending in_valid ignored, then full reload.
        reset_dut();
        do_start();
        stim_q = '{10'd5, 10'h011, 10'h3F0};
        send(1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("stall_hold", 64'({in_ready, mem_we, words_loaded}), 64'({1'b1, 1'b0, 10'd2}));
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset", 64'(outs()), 64'({1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 10'd0}));
        @(negedge clk);
        in_valid = 1'b1; in_data = 10'd5;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_after_reset", 64'({in_ready, words_loaded, cpu_hold}), 64'({1'b0, 10'd0, 1'b1}));
        chk("writes_before_reset", 64'(wr_q.size()), 64'd2);
        in_valid = 1'b0;
        wr_q.delete();
        do_start();
        stim_q = '{10'd5, 10'h011, 10'h3F0, 10'h123, 10'h200, 10'h0AB, 10'h3CF};
        send(1'b0);
        chk("reload_done", 64'({done, error, words_loaded}), 64'({1'b1, 1'b0, 10'd5}));
        check_writes("reload", 1'b0, 10'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter BASE_ADDR, default 10'd0, first instruction-memory address written.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a (re)load; sampled in IDLE, DONE and ERR only.
REQ-005 in_valid  input  1  source has a word on in_data.
REQ-006 in_data  input  10  stream word: header, payload or checksum.
REQ-007 in_ready  output  1  loader accepts in_data this cycle; transfer = in_valid & in_ready.
REQ-008 mem_we  output  1  instruction-memory write strobe, one cycle per payload word.
REQ-009 mem_addr  output  10  instruction-memory write address.
REQ-010 mem_wdata  output  10  instruction-memory write data.
REQ-011 cpu_hold  output  1  high = keep pipelined CPU in reset.
REQ-012 done  output  1  high = image loaded and checksum verified.
REQ-013 error  output  1  high = zero-length header or checksum mismatch.
REQ-014 words_loaded  output  10  payload words written in the current/last load.

Function
REQ-015 FSM states SHALL be IDLE, HDR, DATA, CSUM, DONE, ERR.
REQ-016 Stream format: one header word N (payload count, 1..1023), N payload words, one checksum word = sum of payload words mod 1024.
REQ-017 in_ready SHALL be high exactly in HDR, DATA, CSUM (decoded from state); no word accepted elsewhere.
REQ-018 IDLE: start=1 -> HDR next cycle.
REQ-019 HDR: on transfer, in_data==0 -> ERR; else latch N, clear index, sum and words_loaded, -> DATA.
REQ-020 DATA: each transfer SHALL, one cycle later, drive mem_we=1, mem_addr=(BASE_ADDR+index) mod 1024, mem_wdata=word; index, words_loaded increment; sum += word mod 1024.
REQ-021 DATA: transfer with index==N-1 -> CSUM; back-to-back transfers each cycle SHALL be sustained with no bubble.
REQ-022 mem_we SHALL be low in every cycle not following a DATA transfer; mem_addr/mem_wdata hold last values.
REQ-023 in_valid low SHALL stall the FSM indefinitely with no state, counter or memory change.
REQ-024 CSUM: transfer with in_data==sum -> DONE; otherwise -> ERR.
REQ-025 DONE: done=1, cpu_hold=0; start=1 -> HDR, clears done and reasserts cpu_hold the next cycle.
REQ-026 ERR: error=1, cpu_hold=1; start=1 -> HDR, clears error the next cycle.
REQ-027 start in HDR, DATA or CSUM SHALL be ignored.
REQ-028 cpu_hold SHALL be 1 in every state except DONE; done/error mutually exclusive.
REQ-029 Address wrap: BASE_ADDR+index beyond 1023 SHALL wrap to 0 without error.
REQ-030 All outputs except in_ready SHALL be registered.

Reset
REQ-031 rst=1 at any time, including mid-DATA, SHALL force IDLE immediately: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, error=0, words_loaded=0, N/index/sum cleared.
REQ-032 After rst release the loader SHALL stay in IDLE until start=1; pending in_valid ignored.

Verification
REQ-033 BASE_ADDR=0; start; stream 3,0x101,0x002,0x0FF,0x202 with in_valid constant -> writes (0,0x101),(1,0x002),(2,0x0FF) on consecutive cycles; done=1, cpu_hold=0, words_loaded=3.
REQ-034 Same payload, checksum 0x203 -> 3 writes occur, then error=1, done=0, cpu_hold=1; start + correct stream -> done=1, error=0.
REQ-035 Header 0 -> ERR next cycle, no mem_we, words_loaded=0, cpu_hold=1.
REQ-036 BASE_ADDR=10'd1022, N=4, payload 1,2,3,4, checksum 10 -> addresses 1022,1023,0,1; done=1.
REQ-037 in_valid toggled randomly during N=5 load -> exactly 5 mem_we pulses, data/order unchanged, done=1; start during DATA has no effect.
REQ-038 rst asserted after 2 of 5 payload words -> all outputs at reset values same cycle; later start + full 5-word stream -> done=1, words_loaded=5.
